fc_layer_seq: RTL and testbench

//  Parametrised, sequential fully-connected layer: y[j] = sat(round(sum_i w[j][i]*x[i] + b[j])), optional ReLU.

---
 rtl/fc_pkg.sv | 50 +++++
 rtl/fc_mac_unit.sv | 41 ++++
 rtl/fc_layer_seq.sv | 158 +++++++++++++++
 tb/tb_fc_layer_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for fully-connected layer blocks: FSM states, sizing helpers
// and the common round/saturate/ReLU output stage.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        STORE,
        DONE
    } fc_state_e;

    function automatic int addrWidth(input int nIn, input int nOut);
        return $clog2(nIn * nOut + nOut);
    endfunction

    function automatic int accWidth(input int dataW, input int nIn);
        return 2 * dataW + $clog2(nIn) + 1;
    endfunction

    function automatic int biasBase(input int nIn, input int nOut);
        return nIn * nOut;
    endfunction

    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Value carries FRAC_W extra fractional bits; result fits in dataW signed bits.
    function automatic logic signed [63:0] roundSatRelu(input logic signed [63:0] value,
                                                        input int dataW,
                                                        input int fracW,
                                                        input logic relu);
        logic signed [63:0] r;
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        r    = (value + (64'sd1 <<< (fracW - 1))) >>> fracW;
        maxV = (64'sd1 <<< (dataW - 1)) - 64'sd1;
        minV = -(64'sd1 <<< (dataW - 1));
        if (r > maxV) begin
            r = maxV;
        end else if (r < minV) begin
            r = minV;
        end
        if (relu && (r < 64'sd0)) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Signed multiply-accumulate with bias add and the shared output stage.
module fc_mac_unit import fc_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int N_IN   = 120,
    localparam int ACC_W = accWidth(DATA_W, N_IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic                     i_relu,
    input  logic signed [DATA_W-1:0] i_x,
    input  logic signed [DATA_W-1:0] i_w,
    input  logic signed [DATA_W-1:0] i_bias,
    output logic signed [DATA_W-1:0] o_y
);

    logic signed [ACC_W-1:0]    r_acc;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [63:0]         w_sum;
    logic signed [63:0]         w_res;

    assign w_prod = i_x * i_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_prod);
        end
    end

    // Bias is aligned to the product's doubled fractional scale before rounding.
    assign w_sum = 64'(r_acc) + (64'(i_bias) <<< FRAC_W);
    assign w_res = roundSatRelu(w_sum, DATA_W, FRAC_W, i_relu);
    assign o_y   = DATA_W'(w_res);

endmodule

// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: one MAC per clock over a register-array
// weight/bias store, start/done handshake, results held between runs.
module fc_layer_seq import fc_pkg::*; #(
    parameter int N_IN   = 120,
    parameter int N_OUT  = 10,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    localparam int ADDR_W = addrWidth(N_IN, N_OUT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    start,
    input  logic                    relu_en,
    input  logic [N_IN*DATA_W-1:0]  iFCinput,
    output logic                    busy,
    output logic                    done,
    output logic [N_OUT*DATA_W-1:0] CNNoutput
);

    localparam int DEPTH     = N_IN * N_OUT + N_OUT;
    localparam int BIAS_BASE = biasBase(N_IN, N_OUT);
    localparam int I_W       = cntWidth(N_IN);
    localparam int J_W       = cntWidth(N_OUT);

    fc_state_e               r_state;
    fc_state_e               w_next;
    logic [DATA_W-1:0]       r_store [DEPTH];
    logic [N_IN*DATA_W-1:0]  r_x;
    logic                    r_relu;
    logic [I_W-1:0]          r_i;
    logic [J_W-1:0]          r_j;
    logic [ADDR_W-1:0]       r_wAddr;
    logic [ADDR_W-1:0]       w_rdAddr;
    logic [N_OUT*DATA_W-1:0] r_shadow;
    logic [N_OUT*DATA_W-1:0] w_shadowNext;
    logic [N_OUT*DATA_W-1:0] r_out;
    logic [DATA_W-1:0]       w_rdData;
    logic [DATA_W-1:0]       w_x;
    logic [DATA_W-1:0]       w_y;
    logic                    w_clr;
    logic                    w_en;
    logic                    w_lastI;
    logic                    w_lastJ;

    assign w_lastI  = (r_i == I_W'(N_IN - 1));
    assign w_lastJ  = (r_j == J_W'(N_OUT - 1));
    assign w_rdAddr = (r_state == STORE) ? ADDR_W'(BIAS_BASE) + ADDR_W'(r_j) : r_wAddr;
    assign w_rdData = r_store[w_rdAddr];
    assign w_x      = r_x[r_i*DATA_W +: DATA_W];

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign CNNoutput = r_out;

    always_ff @(posedge clk) begin
        if (wr_en && !busy && (32'(wr_addr) < DEPTH)) begin
            r_store[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = MAC;
                    w_clr  = 1'b1;
                end
            end
            MAC: begin
                w_en = 1'b1;
                if (w_lastI) begin
                    w_next = STORE;
                end
            end
            STORE: begin
                w_clr  = 1'b1;
                w_next = w_lastJ ? DONE : MAC;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_shadowNext = r_shadow;
        w_shadowNext[r_j*DATA_W +: DATA_W] = w_y;
    end

    // The last neuron goes straight to the output register so results are valid with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x      <= '0;
            r_relu   <= 1'b0;
            r_i      <= '0;
            r_j      <= '0;
            r_wAddr  <= '0;
            r_shadow <= '0;
            r_out    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x     <= iFCinput;
                        r_relu  <= relu_en;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_wAddr <= '0;
                    end
                end
                MAC: begin
                    r_i     <= r_i + I_W'(1);
                    r_wAddr <= r_wAddr + ADDR_W'(1);
                end
                STORE: begin
                    r_shadow <= w_shadowNext;
                    r_i      <= '0;
                    r_j      <= w_lastJ ? '0 : r_j + J_W'(1);
                    if (w_lastJ) begin
                        r_out <= w_shadowNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    fc_mac_unit #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .N_IN   (N_IN)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .i_relu (r_relu),
        .i_x    (w_x),
        .i_w    (w_rdData),
        .i_bias (w_rdData),
        .o_y    (w_y)
    );

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq (4 inputs, 2 outputs, Q8.8): vector table plus
// hand-written reset-abort and busy-disturbance sequences.
module tb_fc_layer_seq;

    typedef struct packed {
        logic [7:0][15:0] w;
        logic [1:0][15:0] b;
        logic [3:0][15:0] x;
        logic             relu;
        logic [15:0]      y0;
        logic [15:0]      y1;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        relu_en;
    logic [63:0] iFCinput;
    logic        busy;
    logic        done;
    logic [31:0] CNNoutput;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] prevOut = '0;
    vec_t        vecs[9];

    fc_layer_seq #(
        .N_IN   (4),
        .N_OUT  (2),
        .DATA_W (16),
        .FRAC_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .relu_en   (relu_en),
        .iFCinput  (iFCinput),
        .busy      (busy),
        .done      (done),
        .CNNoutput (CNNoutput)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic writeWord(input logic [3:0] addr, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    // Loads weights and biases, then pokes every address past the store, which must be dropped.
    task automatic applyStimulus(input vec_t v);
        for (int k = 0; k < 8; k++) begin
            writeWord(4'(k), v.w[k]);
        end
        writeWord(4'd8, v.b[0]);
        writeWord(4'd9, v.b[1]);
        for (int k = 10; k < 16; k++) begin
            writeWord(4'(k), 16'h7FFF);
        end
    endtask

    task automatic runVec(input vec_t v, input bit disturb, input int abortAt, input string tag);
        int cyc;
        int busyCnt;
        int doneCnt;
        bit seenDone;
        iFCinput = v.x;
        relu_en  = v.relu;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        iFCinput = ~v.x;
        relu_en  = ~v.relu;
        cyc      = 1;
        busyCnt  = 0;
        seenDone = 1'b0;
        checkOutput($sformatf("%s hold", tag), CNNoutput, prevOut);
        while (cyc <= 40) begin
            if (abortAt != 0 && cyc == abortAt) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                checkOutput($sformatf("%s abort busy", tag), 32'(busy), 32'd0);
                checkOutput($sformatf("%s abort done", tag), 32'(done), 32'd0);
                checkOutput($sformatf("%s abort out", tag), CNNoutput, 32'd0);
                doneCnt = 0;
                for (int k = 0; k < 20; k++) begin
                    if (done || busy) doneCnt++;
                    tick();
                end
                checkOutput($sformatf("%s abort quiet", tag), 32'(doneCnt), 32'd0);
                prevOut = '0;
                return;
            end
            if (disturb && cyc == 3) begin
                wr_en   = 1'b1;
                wr_addr = 4'd0;
                wr_data = 16'h7FFF;
                start   = 1'b1;
            end else if (disturb && cyc == 4) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            if (busy) busyCnt++;
            if (done) begin
                seenDone = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        checkOutput($sformatf("%s done seen", tag), 32'(seenDone), 32'd1);
        checkOutput($sformatf("%s done cycle", tag), 32'(cyc), 32'd11);
        checkOutput($sformatf("%s busy cycles", tag), 32'(busyCnt), 32'd11);
        checkOutput($sformatf("%s y0", tag), 32'(CNNoutput[15:0]), 32'(v.y0));
        checkOutput($sformatf("%s y1", tag), 32'(CNNoutput[31:16]), 32'(v.y1));
        tick();
        checkOutput($sformatf("%s post done", tag), {30'd0, busy, done}, 32'd0);
        prevOut = {v.y1, v.y0};
    endtask

    initial begin
        int extra;
        vecs[0] = '{w: {8{16'h0100}}, b: {16'h0000, 16'h0080},
                    x: {16'h0400, 16'h0300, 16'h0200, 16'h0100}, relu: 1'b0, y0: 16'h0A80, y1: 16'h0A00};
        vecs[1] = '{w: {8{16'h7FFF}}, b: {16'h7FFF, 16'h7FFF},
                    x: {4{16'h7FFF}}, relu: 1'b0, y0: 16'h7FFF, y1: 16'h7FFF};
        vecs[2] = '{w: {8{16'h8000}}, b: {16'h0000, 16'h0000},
                    x: {4{16'h7FFF}}, relu: 1'b0, y0: 16'h8000, y1: 16'h8000};
        vecs[3] = '{w: {8{16'hFF00}}, b: {16'h0000, 16'h0000},
                    x: {4{16'h0100}}, relu: 1'b0, y0: 16'hFC00, y1: 16'hFC00};
        vecs[4] = '{w: {8{16'hFF00}}, b: {16'h0000, 16'h0000},
                    x: {4{16'h0100}}, relu: 1'b1, y0: 16'h0000, y1: 16'h0000};
        vecs[5] = '{w: {{7{16'h0000}}, 16'h0080}, b: {16'h0000, 16'h0000},
                    x: {16'h0000, 16'h0000, 16'h0000, 16'h0001}, relu: 1'b0, y0: 16'h0001, y1: 16'h0000};
        vecs[6] = '{w: {{7{16'h0000}}, 16'hFF80}, b: {16'h0000, 16'h0000},
                    x: {16'h0000, 16'h0000, 16'h0000, 16'h0001}, relu: 1'b0, y0: 16'h0000, y1: 16'h0000};
        vecs[7] = '{w: {16'h1234, 16'h0000, 16'h0300, 16'hFF80, 16'h7FFF, 16'h0400, 16'h0100, 16'h0200},
                    b: {16'h0010, 16'hFF00}, x: {16'h0000, 16'h0040, 16'hFF00, 16'h0180},
                    relu: 1'b0, y0: 16'h0200, y1: 16'hFC50};
        vecs[8] = vecs[7];
        vecs[8].relu = 1'b1;
        vecs[8].y1   = 16'h0000;

        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        start    = 1'b0;
        relu_en  = 1'b0;
        iFCinput = '0;
        tick();
        tick();
        start = 1'b1;
        tick();
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset out", CNNoutput, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        checkOutput("start under reset", 32'(busy), 32'd0);

        for (int t = 0; t < 9; t++) begin
            applyStimulus(vecs[t]);
            runVec(vecs[t], 1'b0, 0, $sformatf("vec%0d", t));
        end

        applyStimulus(vecs[0]);
        runVec(vecs[0], 1'b0, 5, "abort");
        runVec(vecs[0], 1'b0, 0, "restart");

        applyStimulus(vecs[7]);
        runVec(vecs[7], 1'b1, 0, "disturb");
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            if (busy || done) extra++;
            tick();
        end
        checkOutput("no extra run", 32'(extra), 32'd0);
        runVec(vecs[7], 1'b0, 0, "store intact");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
